sal_arb_ingress_fifo_4ch: RTL and testbench

Per-requester ingress buffer bank that sits directly upstream of the 4-to-1 round-robin arbiter. Each of REQ_CNT channels accepts writes through a valid/ready handshake and stores them in an independent circular FIFO. Each channel presents its head entry to the arbiter as req/data. An entry is popped when the arbiter returns a grant for that channel.

---
 rtl/sal_arb_ingress_fifo_4ch.sv | 67 ++++++
 tb/tb_sal_arb_ingress_fifo_4ch.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_arb_ingress_fifo_4ch.sv
`default_nettype none
// ============================================================================
// Module      : sal_arb_ingress_fifo_4ch
// Description : Per-requester circular FIFO bank feeding a round-robin arbiter.
//               Each channel buffers writes and presents its head as req/data.
// Revision    : 1.0 - initial release
// ============================================================================
module sal_arb_ingress_fifo_4ch #(
  parameter int REQ_CNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int DEPTH_LG2  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQ_CNT-1:0]    valid_arr_i,
  input  logic [DATA_WIDTH-1:0] data_arr_i [0:REQ_CNT-1],
  output logic [REQ_CNT-1:0]    ready_arr_o,
  output logic [REQ_CNT-1:0]    req_arr_o,
  output logic [DATA_WIDTH-1:0] data_arr_o [0:REQ_CNT-1],
  input  logic [REQ_CNT-1:0]    gnt_arr_i,
  output logic [DEPTH_LG2:0]    cnt_arr_o  [0:REQ_CNT-1]
);

  localparam logic [DEPTH_LG2:0] c_full = (DEPTH_LG2+1)'(DEPTH);

  for (genvar g = 0; g < REQ_CNT; g++) begin : g_ch
    logic [DEPTH_LG2-1:0]  r_wptr;
    logic [DEPTH_LG2-1:0]  r_rptr;
    logic [DEPTH_LG2:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic                  w_ready;
    logic                  w_req;
    logic                  w_push;
    logic                  w_pop;

    // Ready derives from registered occupancy only, so grants never reach the writers.
    assign w_ready = rst_n & (r_cnt != c_full);
    assign w_req   = (r_cnt != '0);
    assign w_push  = valid_arr_i[g] & w_ready;
    assign w_pop   = gnt_arr_i[g] & w_req;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
        else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= data_arr_i[g];
    end

    assign ready_arr_o[g] = w_ready;
    assign req_arr_o[g]   = w_req;
    assign data_arr_o[g]  = w_req ? r_mem[r_rptr] : '0;
    assign cnt_arr_o[g]   = r_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_sal_arb_ingress_fifo_4ch.sv
`default_nettype none
// ============================================================================
// Module      : tb_sal_arb_ingress_fifo_4ch
// Description : Self-checking bench with per-channel queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sal_arb_ingress_fifo_4ch;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  valid_arr_i = '0;
  logic [DW-1:0] data_arr_i [0:N-1];
  logic [N-1:0]  ready_arr_o;
  logic [N-1:0]  req_arr_o;
  logic [DW-1:0] data_arr_o [0:N-1];
  logic [N-1:0]  gnt_arr_i = '0;
  logic [2:0]    cnt_arr_o  [0:N-1];

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q [N][$];

  always #5 clk = ~clk;

  sal_arb_ingress_fifo_4ch #(
    .REQ_CNT(N), .DATA_WIDTH(DW), .DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_arr_i(valid_arr_i), .data_arr_i(data_arr_i),
    .ready_arr_o(ready_arr_o), .req_arr_o(req_arr_o),
    .data_arr_o(data_arr_o), .gnt_arr_i(gnt_arr_i),
    .cnt_arr_o(cnt_arr_o)
  );

  // Model advance: one clock edge, queues updated from the pre-edge occupancy.
  task automatic tick();
    bit            push [N];
    bit            pop  [N];
    logic [DW-1:0] d    [N];
    for (int c = 0; c < N; c++) begin
      push[c] = valid_arr_i[c] && rst_n && (q[c].size() < D);
      pop[c]  = gnt_arr_i[c] && (q[c].size() > 0);
      d[c]    = data_arr_i[c];
    end
    @(posedge clk);
    for (int c = 0; c < N; c++) begin
      if (pop[c])  void'(q[c].pop_front());
      if (push[c]) q[c].push_back(d[c]);
    end
    #1;
  endtask

  task automatic clear_inputs();
    valid_arr_i = '0;
    gnt_arr_i   = '0;
    for (int c = 0; c < N; c++) data_arr_i[c] = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if (ready_arr_o !== 4'b0000 || req_arr_o !== 4'b0000 || cnt_arr_o[0] !== 3'd0) begin
      n_err++;
      $display("FAIL reset_hold: ready=%b req=%b cnt0=%0d, want 0000/0000/0", ready_arr_o, req_arr_o, cnt_arr_o[0]);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ready_arr_o !== 4'b1111 || req_arr_o !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_release: ready=%b req=%b, want 1111/0000", ready_arr_o, req_arr_o);
    end
    valid_arr_i[0] = 1'b1;
    data_arr_i[0]  = 64'h11;
    tick();
    data_arr_i[0]  = 64'h12;
    tick();
    clear_inputs();
    n_cmp++;
    if (cnt_arr_o[0] !== 3'd2 || req_arr_o[0] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_prefill: cnt0=%0d req0=%b, want 2/1", cnt_arr_o[0], req_arr_o[0]);
    end
    #2;
    rst_n = 1'b0;
    for (int c = 0; c < N; c++) q[c].delete();
    #1;
    n_cmp++;
    if (req_arr_o !== 4'b0000 || cnt_arr_o[0] !== 3'd0 || data_arr_o[0] !== 64'd0 || ready_arr_o !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_async: req=%b cnt0=%0d data0=%h ready=%b, want 0000/0/0/0000",
               req_arr_o, cnt_arr_o[0], data_arr_o[0], ready_arr_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ready_arr_o !== 4'b1111 || req_arr_o !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_after: ready=%b req=%b, want 1111/0000", ready_arr_o, req_arr_o);
    end
  endtask

  task automatic test_latency_order();
    logic [DW-1:0] vals [3];
    vals[0] = 64'hA1; vals[1] = 64'hA2; vals[2] = 64'hA3;
    valid_arr_i[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_arr_i[2] = vals[k];
      tick();
      if (k == 0) begin
        n_cmp++;
        if (req_arr_o[2] !== 1'b1) begin
          n_err++;
          $display("FAIL latency_req: req2=%b, want 1", req_arr_o[2]);
        end
      end
    end
    clear_inputs();
    n_cmp++;
    if (cnt_arr_o[2] !== 3'd3) begin
      n_err++;
      $display("FAIL latency_cnt: cnt2=%0d, want 3", cnt_arr_o[2]);
    end
    gnt_arr_i[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (data_arr_o[2] !== vals[k]) begin
        n_err++;
        $display("FAIL order_data%0d: data2=%h, want %h", k, data_arr_o[2], vals[k]);
      end
      tick();
    end
    gnt_arr_i = '0;
    n_cmp++;
    if (req_arr_o[2] !== 1'b0 || data_arr_o[2] !== 64'd0) begin
      n_err++;
      $display("FAIL order_empty: req2=%b data2=%h, want 0/0", req_arr_o[2], data_arr_o[2]);
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] exp [5];
    for (int k = 0; k < 4; k++) exp[k] = 64'hB0 + 64'(k);
    exp[4] = 64'hFF;
    valid_arr_i[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_arr_i[1] = exp[k];
      tick();
    end
    n_cmp++;
    if (ready_arr_o[1] !== 1'b0 || cnt_arr_o[1] !== 3'd4) begin
      n_err++;
      $display("FAIL full_ready: ready1=%b cnt1=%0d, want 0/4", ready_arr_o[1], cnt_arr_o[1]);
    end
    data_arr_i[1] = 64'hFF;
    gnt_arr_i[1]  = 1'b1;
    tick();
    gnt_arr_i[1]  = 1'b0;
    n_cmp++;
    if (cnt_arr_o[1] !== 3'd3 || ready_arr_o[1] !== 1'b1) begin
      n_err++;
      $display("FAIL full_pop: cnt1=%0d ready1=%b, want 3/1", cnt_arr_o[1], ready_arr_o[1]);
    end
    tick();
    valid_arr_i[1] = 1'b0;
    n_cmp++;
    if (cnt_arr_o[1] !== 3'd4) begin
      n_err++;
      $display("FAIL full_refill: cnt1=%0d, want 4", cnt_arr_o[1]);
    end
    gnt_arr_i[1] = 1'b1;
    for (int k = 1; k < 5; k++) begin
      n_cmp++;
      if (data_arr_o[1] !== exp[k]) begin
        n_err++;
        $display("FAIL full_drain%0d: data1=%h, want %h", k, data_arr_o[1], exp[k]);
      end
      tick();
    end
    clear_inputs();
    n_cmp++;
    if (req_arr_o[1] !== 1'b0) begin
      n_err++;
      $display("FAIL full_empty: req1=%b, want 0", req_arr_o[1]);
    end
  endtask

  task automatic test_back_to_back();
    valid_arr_i[3] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      data_arr_i[3] = 64'hC00 + 64'(k);
      tick();
    end
    gnt_arr_i[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      data_arr_i[3] = 64'hC00 + 64'(k + 2);
      n_cmp++;
      if (cnt_arr_o[3] !== 3'd2 || data_arr_o[3] !== 64'hC00 + 64'(k)) begin
        n_err++;
        $display("FAIL b2b_%0d: cnt3=%0d data3=%h, want 2/%h", k, cnt_arr_o[3], data_arr_o[3], 64'hC00 + 64'(k));
      end
      tick();
    end
    valid_arr_i[3] = 1'b0;
    for (int k = 10; k < 12; k++) begin
      n_cmp++;
      if (data_arr_o[3] !== 64'hC00 + 64'(k)) begin
        n_err++;
        $display("FAIL b2b_drain%0d: data3=%h, want %h", k, data_arr_o[3], 64'hC00 + 64'(k));
      end
      tick();
    end
    clear_inputs();
    n_cmp++;
    if (req_arr_o[3] !== 1'b0 || cnt_arr_o[3] !== 3'd0) begin
      n_err++;
      $display("FAIL b2b_empty: req3=%b cnt3=%0d, want 0/0", req_arr_o[3], cnt_arr_o[3]);
    end
  endtask

  task automatic test_spurious_grant();
    gnt_arr_i      = 4'b1111;
    valid_arr_i[0] = 1'b1;
    data_arr_i[0]  = 64'hD0D0;
    tick();
    clear_inputs();
    n_cmp++;
    if (cnt_arr_o[0] !== 3'd1 || req_arr_o !== 4'b0001 || data_arr_o[0] !== 64'hD0D0) begin
      n_err++;
      $display("FAIL spurious: cnt0=%0d req=%b data0=%h, want 1/0001/d0d0", cnt_arr_o[0], req_arr_o, data_arr_o[0]);
    end
    n_cmp++;
    if (cnt_arr_o[1] !== 3'd0 || cnt_arr_o[2] !== 3'd0 || cnt_arr_o[3] !== 3'd0) begin
      n_err++;
      $display("FAIL spurious_underflow: cnt1=%0d cnt2=%0d cnt3=%0d, want 0", cnt_arr_o[1], cnt_arr_o[2], cnt_arr_o[3]);
    end
    gnt_arr_i[0] = 1'b1;
    tick();
    gnt_arr_i = '0;
  endtask

  // Behavioural round-robin arbiter driving the grants.
  task automatic test_arbiter();
    int last = N - 1;
    int seen [N];
    int total = 0;
    int turn = 0;
    valid_arr_i = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < N; c++) data_arr_i[c] = (64'(c) << 8) | 64'(k);
      tick();
    end
    clear_inputs();
    for (int c = 0; c < N; c++) seen[c] = 0;
    for (int cyc = 0; cyc < 40 && total < 12; cyc++) begin
      int g = -1;
      for (int k = 1; k <= N; k++) begin
        int c = (last + k) % N;
        if (g < 0 && req_arr_o[c]) g = c;
      end
      gnt_arr_i = '0;
      if (g >= 0) begin
        gnt_arr_i[g] = 1'b1;
        n_cmp++;
        if (g != turn % N || data_arr_o[g] !== ((64'(g) << 8) | 64'(seen[g]))) begin
          n_err++;
          $display("FAIL arb_%0d: ch=%0d data=%h, want ch=%0d data=%h", total, g, data_arr_o[g],
                   turn % N, (64'(turn % N) << 8) | 64'(seen[turn % N]));
        end
        seen[g]++;
        last = g;
        total++;
        turn++;
      end
      tick();
    end
    gnt_arr_i = '0;
    n_cmp++;
    if (total != 12 || req_arr_o !== 4'b0000) begin
      n_err++;
      $display("FAIL arb_total: popped=%0d req=%b, want 12/0000", total, req_arr_o);
    end
  endtask

  task automatic test_random();
    bit            vld [N];
    logic [DW-1:0] dat [N];
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  exp_req;
    bit            acc [N];
    for (int c = 0; c < N; c++) vld[c] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (!vld[c] && ($urandom_range(0, 2) != 0)) begin
          vld[c] = 1'b1;
          dat[c] = {$urandom, $urandom};
        end
        valid_arr_i[c] = vld[c];
        data_arr_i[c]  = vld[c] ? dat[c] : '0;
        exp_ready[c]   = (q[c].size() < D);
        exp_req[c]     = (q[c].size() > 0);
        acc[c]         = vld[c] && exp_ready[c];
      end
      gnt_arr_i = 4'($urandom_range(0, 15));
      n_cmp++;
      if (ready_arr_o !== exp_ready || req_arr_o !== exp_req) begin
        n_err++;
        $display("FAIL rand_flags@%0d: ready=%b req=%b, want %b/%b", cyc, ready_arr_o, req_arr_o, exp_ready, exp_req);
      end
      for (int c = 0; c < N; c++) begin
        logic [DW-1:0] ed;
        ed = (q[c].size() > 0) ? q[c][0] : '0;
        n_cmp++;
        if (cnt_arr_o[c] !== 3'(q[c].size()) || data_arr_o[c] !== ed) begin
          n_err++;
          $display("FAIL rand_ch%0d@%0d: cnt=%0d data=%h, want %0d/%h", c, cyc, cnt_arr_o[c], data_arr_o[c], q[c].size(), ed);
        end
      end
      tick();
      for (int c = 0; c < N; c++) if (acc[c]) vld[c] = 1'b0;
    end
    clear_inputs();
  endtask

  initial begin
    for (int c = 0; c < N; c++) data_arr_i[c] = '0;
    test_reset();
    test_latency_order();
    test_full();
    test_back_to_back();
    test_spurious_grant();
    test_arbiter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
